pwd_ctrl: RTL and testbench



---
 rtl/pwd_pkg.sv | 14 +
 rtl/pwd_ctrl_lock_timer.sv | 30 +++
 rtl/pwd_ctrl.sv | 140 ++++++++++++++
 tb/tb_pwd_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwd_pkg.sv
// rtl/pwd_pkg.sv - shared state encoding and sizing constants for the password controller
package pwd_pkg;
    localparam int DEPTH = 64;
    localparam int PTR_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_CHECK,
        S_DRAIN,
        S_RESULT,
        S_LOCK
    } state_t;
endpackage

// File: rtl/pwd_ctrl_lock_timer.sv
// rtl/pwd_ctrl_lock_timer.sv - loadable down-counter; busy spans load_val+1 cycles after a load
module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         expire
);
    logic [W-1:0] cnt_q;
    logic         busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= load_val;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign busy   = busy_q;
    assign expire = busy_q && (cnt_q == '0);
endmodule

// File: rtl/pwd_ctrl.sv
// rtl/pwd_ctrl.sv - program/check sequencer for the password RAM with failed-attempt lockout
module pwd_ctrl
    import pwd_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_set,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              done,
    output logic              match,
    output logic              locked,
    output logic [ADDR_W:0]   pwd_len
);
    localparam int PW  = ADDR_W + 1;
    localparam int DEP = 2**ADDR_W;
    localparam int FW  = $clog2(MAX_FAIL + 1);
    localparam int TW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   pwd_len_q;
    logic [FW-1:0]   fail_q;
    logic            mis_q;
    logic            match_q;
    logic            done_q;
    logic            is_check_q;

    logic            xfer;
    logic            mis_d;
    logic [FW-1:0]   fail_d;
    logic            lock_load;
    logic            lock_busy;
    logic            lock_expire;

    assign in_ready  = (state_q == S_PROG) || (state_q == S_CHECK) || (state_q == S_DRAIN);
    assign xfer      = in_valid && in_ready;
    assign ram_we    = (state_q == S_PROG) && in_valid;
    assign ram_addr  = ((state_q == S_PROG) || (state_q == S_CHECK)) ? ptr_q[ADDR_W-1:0] : '0;
    assign ram_wdata = (state_q == S_PROG) ? in_data : '0;

    // Bytes beyond the stored length always mismatch, which also makes an empty password unmatchable.
    assign mis_d     = mis_q || (ptr_q >= pwd_len_q) || (in_data != ram_rdata);
    assign fail_d    = fail_q + 1'b1;
    assign lock_load = (state_q == S_RESULT) && is_check_q && !match_q
                       && (32'(fail_d) >= MAX_FAIL);

    lock_timer #(.W(TW)) u_lock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (TW'(LOCK_CYCLES - 1)),
        .busy     (lock_busy),
        .expire   (lock_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            pwd_len_q  <= '0;
            fail_q     <= '0;
            mis_q      <= 1'b0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            is_check_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    match_q    <= 1'b0;
                    ptr_q      <= '0;
                    mis_q      <= 1'b0;
                    is_check_q <= !mode_set;
                    state_q    <= mode_set ? S_PROG : S_CHECK;
                end
                S_PROG: if (xfer) begin
                    if (in_last) begin
                        pwd_len_q <= ptr_q + 1'b1;
                        match_q   <= 1'b1;
                        fail_q    <= '0;
                        done_q    <= 1'b1;
                        state_q   <= S_RESULT;
                    end else if (ptr_q == PW'(DEP - 1)) begin
                        pwd_len_q <= '0;
                        state_q   <= S_DRAIN;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                S_DRAIN: if (xfer && in_last) begin
                    match_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_RESULT;
                end
                S_CHECK: if (xfer) begin
                    mis_q <= mis_d;
                    if (in_last) begin
                        match_q <= !mis_d && ((ptr_q + 1'b1) == pwd_len_q);
                        done_q  <= 1'b1;
                        state_q <= S_RESULT;
                    end else if (ptr_q != PW'(DEP)) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (is_check_q && !match_q) begin
                        fail_q  <= fail_d;
                        state_q <= lock_load ? S_LOCK : S_IDLE;
                    end else begin
                        if (is_check_q) fail_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_LOCK: if (lock_expire) begin
                    fail_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done    = done_q;
    assign match   = match_q;
    assign locked  = lock_busy;
    assign pwd_len = pwd_len_q;
endmodule

// File: tb/tb_pwd_ctrl.sv
// tb/tb_pwd_ctrl.sv - randomized self-checking bench for pwd_ctrl against a stored-password model
module tb_pwd_ctrl;
    import pwd_pkg::*;

    localparam int LOCK_N = 1000;
    localparam int MAXF   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode_set = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready, ram_we, done, match, locked;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic [6:0] pwd_len;

    logic [7:0] ram [DEPTH];
    logic [7:0] mem_m [DEPTH];
    logic [7:0] stim [$];
    int         len_m = 0;
    int         fail_m = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    pwd_ctrl #(.ADDR_W(6), .DATA_W(8), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK_N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_set(mode_set),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .done(done), .match(match), .locked(locked), .pwd_len(pwd_len)
    );

    function automatic bit model_match();
        if (len_m == 0 || stim.size() != len_m) return 1'b0;
        for (int k = 0; k < len_m; k++) if (stim[k] != mem_m[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Streams stim[] through one operation, checking write strobes and done timing as it goes.
    task automatic run_op(input bit prog, input bit gaps, output logic got_match);
        int i = 0, cyc = 0, last_cyc = -1, done_cyc = -1, we_err = 0;
        bit x;
        got_match = 1'bx;
        @(negedge clk); start = 1'b1; mode_set = prog;
        @(negedge clk); start = 1'b0; mode_set = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            if (i < stim.size() && !(gaps && cyc[0])) begin
                in_valid = 1'b1; in_data = stim[i]; in_last = (i == stim.size() - 1);
            end else begin
                in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
            end
            #1;
            if (done === 1'b1) begin
                done_cyc = cyc; got_match = match;
            end else begin
                x = in_valid && in_ready;
                if (x && prog && i < DEPTH) begin
                    if (!(ram_we === 1'b1 && ram_addr === i[5:0] && ram_wdata === stim[i])) we_err++;
                end else if (ram_we !== 1'b0) begin
                    we_err++;
                end
                if (x) begin
                    if (in_last) last_cyc = cyc;
                    i++;
                end
            end
            @(negedge clk); cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        n_tests++;
        if (done_cyc < 0) begin n_fail++; $display("FAIL op_timeout: no done after %0d cycles", cyc); end
        n_tests++;
        if (done_cyc != last_cyc + 1) begin
            n_fail++; $display("FAIL done_latency: done cycle %0d, last transfer cycle %0d", done_cyc, last_cyc);
        end
        n_tests++;
        if (we_err != 0) begin n_fail++; $display("FAIL ram_write_pattern: %0d bad cycles, required 0", we_err); end
        n_tests++;
        if (done !== 1'b0 || match !== got_match) begin
            n_fail++; $display("FAIL done_pulse: done=%b match=%b, required done=0 match=%b", done, match, got_match);
        end
    endtask

    task automatic wait_lock();
        int n = 0, err = 0;
        while (locked === 1'b1 && n < 5000) begin
            start = (n == 10); mode_set = 1'b1;
            if (in_ready !== 1'b0 || done !== 1'b0) err++;
            n++;
            @(negedge clk); #1;
        end
        start = 1'b0; mode_set = 1'b0;
        n_tests++;
        if (n != LOCK_N) begin n_fail++; $display("FAIL lock_duration: %0d cycles, required %0d", n, LOCK_N); end
        n_tests++;
        if (err != 0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL lock_ignores_start: %0d bad cycles, in_ready=%b, required 0", err, in_ready);
        end
    endtask

    task automatic do_prog(input bit gaps, input string name);
        logic m;
        bit   exp;
        exp = (stim.size() <= DEPTH);
        run_op(1'b1, gaps, m);
        n_tests++;
        if (m !== exp) begin n_fail++; $display("FAIL %s_match: got %b required %b", name, m, exp); end
        for (int k = 0; k < stim.size() && k < DEPTH; k++) mem_m[k] = stim[k];
        len_m = exp ? stim.size() : 0;
        if (exp) fail_m = 0;
        n_tests++;
        if (pwd_len !== 7'(len_m)) begin n_fail++; $display("FAIL %s_len: got %0d required %0d", name, pwd_len, len_m); end
    endtask

    task automatic do_check(input bit gaps, input string name);
        logic m;
        bit   exp;
        exp = model_match();
        run_op(1'b0, gaps, m);
        n_tests++;
        if (m !== exp) begin n_fail++; $display("FAIL %s_match: got %b required %b", name, m, exp); end
        fail_m = exp ? 0 : fail_m + 1;
        if (fail_m >= MAXF) begin
            n_tests++;
            if (locked !== 1'b1) begin n_fail++; $display("FAIL %s_lock_entry: locked=%b required 1", name, locked); end
            wait_lock();
            fail_m = 0;
        end else begin
            n_tests++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL %s_unlocked: locked=%b required 0", name, locked); end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, done, match, locked, pwd_len} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0",
                {in_ready, ram_we, ram_addr, ram_wdata, done, match, locked, pwd_len});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_program_abc();
        stim = '{8'h61, 8'h62, 8'h63};
        do_prog(1'b0, "prog_abc");
        do_check(1'b0, "check_abc");
    endtask

    task automatic test_lockout();
        stim = '{8'h61, 8'h62, 8'h64};         do_check(1'b0, "check_abd");
        stim = '{8'h61, 8'h62};                do_check(1'b0, "check_ab");
        stim = '{8'h61, 8'h62, 8'h63, 8'h64};  do_check(1'b0, "check_abcd");
        stim = '{8'h61, 8'h62, 8'h63};         do_check(1'b0, "check_abc_after_lock");
    endtask

    task automatic test_overflow();
        stim.delete();
        for (int k = 0; k < 70; k++) stim.push_back(8'($urandom));
        do_prog(1'b0, "prog_70");
        stim = stim[0:63];
        do_check(1'b0, "check_after_overflow");
    endtask

    task automatic test_boundary_backpressure();
        logic [7:0] full [$];
        stim.delete();
        for (int k = 0; k < 64; k++) stim.push_back(8'($urandom));
        full = stim;
        do_prog(1'b1, "prog_64");
        do_check(1'b0, "check_64");
        do_check(1'b1, "check_64_gaps");
        stim.push_back(8'h5a);
        do_check(1'b1, "check_65");
        stim = full[0:62];
        do_check(1'b0, "check_63");
    endtask

    task automatic test_random();
        logic [7:0] pw [$];
        int n, c;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 70);
            stim.delete();
            for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
            pw = stim;
            do_prog(1'($urandom), "rand_prog");
            do_check(1'($urandom), "rand_exact");
            c = $urandom_range(0, n - 1);
            stim[c] = stim[c] ^ 8'(1 << $urandom_range(0, 7));
            do_check(1'($urandom), "rand_flip");
            stim.delete();
            c = $urandom_range(1, 70);
            for (int k = 0; k < c; k++) stim.push_back(k < pw.size() ? pw[k] : 8'($urandom));
            do_check(1'($urandom), "rand_len");
        end
    endtask

    task automatic test_reset_mid_prog();
        stim = '{8'h61, 8'h62, 8'h63};
        do_prog(1'b0, "prog_before_reset");
        @(negedge clk); start = 1'b1; mode_set = 1'b1;
        @(negedge clk); start = 1'b0; mode_set = 1'b0; in_valid = 1'b1; in_data = 8'h61;
        @(negedge clk); in_data = 8'h62;
        @(negedge clk); in_data = 8'h63;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || ram_addr !== 6'd2) begin
            n_fail++; $display("FAIL mid_prog_state: in_ready=%b addr=%0d required 1 and 2", in_ready, ram_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, done, match, locked, pwd_len} !== '0) begin
            n_fail++; $display("FAIL reset_mid_prog: got %h required 0",
                {in_ready, ram_we, ram_addr, ram_wdata, done, match, locked, pwd_len});
        end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        len_m = 0; fail_m = 0;
        stim = '{8'h61, 8'h62};
        do_check(1'b0, "check_ab_after_reset");
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ram[k] = 8'h00;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
        test_reset();
        test_program_abc();
        test_lockout();
        test_overflow();
        test_boundary_backpressure();
        test_random();
        test_reset_mid_prog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
